usb_bus_mailbox: RTL and testbench

- Bus slave directly downstream of usb_driver. Consumes its internal byte bus: bus_addr, bus_read, bus_write and the bidirectional bus_data.
- Provides two byte FIFOs between the USB host and the CPU core:
  - h2c: host-to-CPU.
  - c2h: CPU-to-host.
- Also provides status, level and control registers, so the host can exchange byte streams with the CPU through the EPP-style link.

---
 rtl/usb_bus_mailbox.sv | 170 +++++++++++++++++
 tb/tb_usb_bus_mailbox.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_bus_mailbox.sv
// Byte-bus slave giving the USB host two byte FIFOs (h2c, c2h) plus status/level/control registers.
// Optional interrupt output and IRQ_MASK register when USB_MBOX_IRQ_EN is defined.
module usb_mbox_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [7:0]            wdata,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Empty FIFO presents 0 so the head never leaks stale storage
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

module usb_bus_mailbox #(
    parameter logic [7:0] BASE_ADDR  = 8'h00,
    parameter int         DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bus_addr,
    input  logic       bus_read,
    input  logic       bus_write,
    inout  wire  [7:0] bus_data,
    output logic [7:0] h2c_data,
    output logic       h2c_valid,
    input  logic       h2c_ready,
    input  logic [7:0] c2h_data,
    input  logic       c2h_valid,
    output logic       c2h_ready
`ifdef USB_MBOX_IRQ_EN
    ,
    output logic       irq
`endif
);
`ifdef USB_MBOX_IRQ_EN
    localparam logic [7:0] NREG = 8'd6;
`else
    localparam logic [7:0] NREG = 8'd5;
`endif

    // Index 0 = h2c, index 1 = c2h
    logic [1:0]                 push, pop, full, empty;
    logic [1:0][7:0]            wdata, head;
    logic [1:0][DEPTH_LOG2:0]   level;

    logic [7:0] offset, rd_mux;
    logic       mapped, flush, clr, host_pop;
    logic       bus_read_q, data_hit_q, ovf, udf;

    assign offset   = bus_addr - BASE_ADDR;
    assign mapped   = (offset < NREG);
    assign flush    = bus_write && (offset == 8'd2) && bus_data[0];
    assign clr      = bus_write && (offset == 8'd2) && bus_data[1];
    // One pop per host read, taken on the falling edge of bus_read
    assign host_pop = !bus_read && bus_read_q && data_hit_q;

    assign push[0]  = bus_write && (offset == 8'd0);
    assign wdata[0] = bus_data;
    assign pop[0]   = h2c_ready;
    assign push[1]  = c2h_valid;
    assign wdata[1] = c2h_data;
    assign pop[1]   = host_pop;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        usb_mbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .push  (push[g]),
            .wdata (wdata[g]),
            .pop   (pop[g]),
            .head  (head[g]),
            .level (level[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    assign h2c_data  = head[0];
    assign h2c_valid = !empty[0];
    assign c2h_ready = !full[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_read_q <= 1'b0;
            data_hit_q <= 1'b0;
            ovf        <= 1'b0;
            udf        <= 1'b0;
        end else begin
            bus_read_q <= bus_read;
            data_hit_q <= bus_read && (offset == 8'd0);
            // Clear beats a same-cycle set
            if (clr) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end else begin
                if (push[0] && full[0])  ovf <= 1'b1;
                if (host_pop && empty[1]) udf <= 1'b1;
            end
        end
    end

`ifdef USB_MBOX_IRQ_EN
    logic [2:0] irq_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_mask <= 3'b000;
            irq      <= 1'b0;
        end else begin
            if (bus_write && (offset == 8'd5)) irq_mask <= bus_data[2:0];
            irq <= |(irq_mask & {ovf | udf, empty[1], h2c_valid});
        end
    end
`endif

    always_comb begin
        rd_mux = 8'h00;
        case (offset)
            8'd0:    rd_mux = head[1];
            8'd1:    rd_mux = {2'b00, udf, ovf, empty[1], full[1], empty[0], full[0]};
            8'd3:    rd_mux = 8'(level[0]);
            8'd4:    rd_mux = 8'(level[1]);
`ifdef USB_MBOX_IRQ_EN
            8'd5:    rd_mux = {5'b00000, irq_mask};
`endif
            default: rd_mux = 8'h00;
        endcase
    end

    assign bus_data = (bus_read && mapped) ? rd_mux : 8'hzz;
endmodule

// File: tb/tb_usb_bus_mailbox.sv
// Scoreboard bench for usb_bus_mailbox: queue-based FIFO model, randomized host/CPU traffic.
module tb_usb_bus_mailbox;
    localparam logic [7:0] BASE  = 8'h00;
    localparam int         DEPTH = 16;
`ifdef USB_MBOX_IRQ_EN
    localparam int NREG = 6;
`else
    localparam int NREG = 5;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] bus_addr = 8'h00;
    logic       bus_read = 1'b0, bus_write = 1'b0;
    logic [7:0] drv = 8'h00;
    logic       drv_en = 1'b0;
    wire  [7:0] bus_data;
    logic [7:0] h2c_data;
    logic       h2c_valid;
    logic       h2c_ready = 1'b0;
    logic [7:0] c2h_data = 8'h00;
    logic       c2h_valid = 1'b0;
    logic       c2h_ready;
`ifdef USB_MBOX_IRQ_EN
    logic       irq;
`endif

    always #5 clk = ~clk;
    assign bus_data = drv_en ? drv : 8'hzz;

    usb_bus_mailbox #(.BASE_ADDR(BASE), .DEPTH_LOG2(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_addr  (bus_addr),
        .bus_read  (bus_read),
        .bus_write (bus_write),
        .bus_data  (bus_data),
        .h2c_data  (h2c_data),
        .h2c_valid (h2c_valid),
        .h2c_ready (h2c_ready),
        .c2h_data  (c2h_data),
        .c2h_valid (c2h_valid),
        .c2h_ready (c2h_ready)
`ifdef USB_MBOX_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    int tests = 0, fails = 0;
    byte unsigned h2c_m[$], c2h_m[$], rd_exp[$];
    string        rd_name[$];
    bit           ovf_m = 0, udf_m = 0, rd_prev = 0;
    logic [2:0]   mask_m = 3'b000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_reg(input logic [7:0] off);
        case (off)
            8'd0: return (c2h_m.size() > 0) ? c2h_m[0] : 8'h00;
            8'd1: return {2'b00, udf_m, ovf_m, c2h_m.size() == 0, c2h_m.size() == DEPTH,
                          h2c_m.size() == 0, h2c_m.size() == DEPTH};
            8'd3: return 8'(h2c_m.size());
            8'd4: return 8'(c2h_m.size());
            8'd5: return {5'b00000, mask_m};
            default: return 8'h00;
        endcase
    endfunction

    // Monitor: checks every CPU pop and the first sampled byte of every host read
    always @(negedge clk) begin
        if (rst_n) begin
            if (h2c_valid && h2c_ready) begin
                chk("h2c_pop_expected", h2c_m.size() != 0, 1);
                if (h2c_m.size() != 0) chk("h2c_data", h2c_data, h2c_m.pop_front());
            end
            if (bus_read && !rd_prev) begin
                chk("rd_expected", rd_exp.size() != 0, 1);
                if (rd_exp.size() != 0) chk(rd_name.pop_front(), bus_data, rd_exp.pop_front());
            end
            rd_prev = bus_read;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [7:0] addr, input logic [7:0] data, input bit rdy,
                              input bit push_en, input logic [7:0] push_byte);
        logic [7:0] off;
        off = addr - BASE;
        bus_addr = addr; drv = data; drv_en = 1'b1; bus_write = 1'b1; h2c_ready = rdy;
        if (push_en) begin
            c2h_data = push_byte; c2h_valid = 1'b1;
            chk("c2h_ready", c2h_ready, c2h_m.size() < DEPTH);
            if (c2h_m.size() < DEPTH) c2h_m.push_back(push_byte);
        end
        if (off == 8'd0) begin
            if (h2c_m.size() < DEPTH) h2c_m.push_back(data);
            else ovf_m = 1;
        end
        if (off == 8'd2) begin
            if (data[0]) begin h2c_m.delete(); c2h_m.delete(); end
            if (data[1]) begin ovf_m = 0; udf_m = 0; end
        end
        if (off == 8'd5 && NREG == 6) mask_m = data[2:0];
        cyc();
        bus_write = 1'b0; drv_en = 1'b0; h2c_ready = 1'b0; c2h_valid = 1'b0;
    endtask

    // Read held for 'hold' cycles, then one bus-idle cycle in which the pop lands
    task automatic host_read(input logic [7:0] addr, input int hold, input bit tail_clr);
        logic [7:0] off;
        off = addr - BASE;
        rd_exp.push_back(exp_reg(off));
        rd_name.push_back($sformatf("rd_reg%0d", off));
        bus_addr = addr; bus_read = 1'b1; h2c_ready = 1'b0;
        repeat (hold) cyc();
        bus_read = 1'b0;
        if (off == 8'd0) begin
            if (c2h_m.size() > 0) void'(c2h_m.pop_front());
            else udf_m = 1;
        end
        if (tail_clr) begin
            bus_addr = BASE + 8'd2; drv = 8'h02; drv_en = 1'b1; bus_write = 1'b1;
            ovf_m = 0; udf_m = 0;
        end
        cyc();
        bus_write = 1'b0; drv_en = 1'b0;
    endtask

    task automatic cpu_push(input logic [7:0] d);
        c2h_data = d; c2h_valid = 1'b1; h2c_ready = 1'b0;
        chk("c2h_ready", c2h_ready, c2h_m.size() < DEPTH);
        if (c2h_m.size() < DEPTH) c2h_m.push_back(d);
        cyc();
        c2h_valid = 1'b0;
    endtask

    task automatic idle(input int n, input int rdy_pct);
        repeat (n) begin
            h2c_ready = ($urandom_range(0, 99) < rdy_pct);
            cyc();
        end
        h2c_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_h2c_valid", h2c_valid, 0);
        chk("rst_h2c_data", h2c_data, 8'h00);
        chk("rst_c2h_ready", c2h_ready, 1);
`ifdef USB_MBOX_IRQ_EN
        chk("rst_irq", irq, 0);
`endif
        host_read(BASE + 8'd1, 1, 0);

        // Single host byte to the CPU
        host_write(BASE, 8'h6A, 0, 0, 8'h00);
        chk("h2c_valid_after_push", h2c_valid, 1);
        chk("h2c_head", h2c_data, 8'h6A);
        host_read(BASE + 8'd3, 1, 0);
        idle(1, 100);
        chk("h2c_valid_after_pop", h2c_valid, 0);

        // Two CPU bytes read by long host reads
        cpu_push(8'h11);
        cpu_push(8'h22);
        host_read(BASE, 3, 0);
        host_read(BASE, 3, 0);
        host_read(BASE + 8'd4, 1, 0);

        // Overfill h2c, then drain
        for (int i = 0; i < 17; i++) host_write(BASE, 8'(i), 0, 0, 8'h00);
        host_read(BASE + 8'd1, 1, 0);
        host_write(BASE, 8'hA5, 1, 0, 8'h00);
        host_read(BASE + 8'd3, 1, 0);
        host_write(BASE, 8'hA6, 1, 0, 8'h00);
        host_read(BASE + 8'd3, 1, 0);
        idle(20, 100);
        chk("h2c_drained", h2c_m.size(), 0);
        chk("h2c_valid_drained", h2c_valid, 0);

        // Underflow, sticky clear, flush against CPU push
        host_read(BASE, 2, 0);
        host_read(BASE + 8'd1, 1, 0);
        host_write(BASE + 8'd2, 8'h02, 0, 0, 8'h00);
        host_read(BASE + 8'd1, 1, 0);
        host_read(BASE, 1, 1);
        host_read(BASE + 8'd1, 1, 0);
        cpu_push(8'h31); cpu_push(8'h32); cpu_push(8'h33);
        host_write(BASE + 8'd2, 8'h01, 0, 1, 8'hEE);
        host_read(BASE + 8'd4, 1, 0);
        host_read(BASE + 8'd2, 1, 0);

`ifdef USB_MBOX_IRQ_EN
        host_write(BASE + 8'd5, 8'h01, 0, 0, 8'h00);
        host_read(BASE + 8'd5, 1, 0);
        host_write(BASE, 8'h55, 0, 0, 8'h00);
        for (int k = 0; k < 3 && !irq; k++) cyc();
        chk("irq_rise", irq, 1);
        idle(1, 100);
        cyc();
        chk("irq_fall", irq, 0);
        host_write(BASE + 8'd5, 8'h00, 0, 0, 8'h00);
`endif

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: host_write(BASE, 8'($urandom), $urandom_range(0, 1), 0, 8'h00);
                3, 4:    cpu_push(8'($urandom));
                5:       host_read(BASE, $urandom_range(1, 4), $urandom_range(0, 3) == 0);
                6:       host_read(BASE + 8'($urandom_range(1, NREG - 1)), 1, 0);
                7:       idle($urandom_range(1, 3), 70);
                8:       host_write(BASE + 8'($urandom_range(6, 255)), 8'($urandom), 0,
                                    $urandom_range(0, 1), 8'($urandom));
                default: host_write(BASE + 8'd2, ($urandom_range(0, 5) == 0) ? 8'h01 : 8'($urandom_range(0, 3) & 2),
                                    0, $urandom_range(0, 1), 8'($urandom));
            endcase
        end

        idle(DEPTH + 4, 100);
        for (int i = 0; i <= DEPTH && c2h_m.size() > 0; i++) host_read(BASE, 1, 0);
        host_read(BASE + 8'd1, 1, 0);
        chk("final_h2c_model_empty", h2c_m.size(), 0);
        chk("final_c2h_model_empty", c2h_m.size(), 0);
        chk("final_h2c_valid", h2c_valid, 0);
        chk("final_rd_consumed", rd_exp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
